// File: rtl/array_sweep_ctrl.sv
// array_sweep_ctrl: fills a ROWS x COLS word array over PASSES passes, offering each write on a valid/ready port
module array_sweep_ctrl #(
    parameter int ROWS = 4,
    parameter int COLS = 2,
    parameter int WIDTH = 16,
    parameter int PASSES = 2,
    parameter int PASS_STRIDE = 10,
    parameter int GAP_CYCLES = 1,
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1,
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1,
    localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1,
    localparam int FW = ROWS * COLS * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_row,
    output logic [CW-1:0]    out_col,
    output logic [PW-1:0]    out_pass,
    output logic [WIDTH-1:0] out_data,
    output logic [FW-1:0]    a_flat,
    output logic             busy,
    output logic             done
);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam int AW = WIDTH + 8;
    typedef enum logic [1:0] {IDLE, FILL, GAP, DONE} state_t;
    state_t state, state_d;
    logic [RW-1:0] row, row_d;
    logic [CW-1:0] col, col_d;
    logic [PW-1:0] pass, pass_d;
    logic [GW-1:0] gap, gap_d;
    logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] arr;
    logic [WIDTH-1:0] data_w;
    logic fill, wr, last_col, last_row, last_pass, last_gap;
    assign fill = state == FILL;
    assign last_col = col == CW'(COLS - 1);
    assign last_row = row == RW'(ROWS - 1);
    assign last_pass = pass == PW'(PASSES - 1);
    assign last_gap = gap == GW'(GAP_CYCLES - 1);
    assign data_w = WIDTH'(AW'(row) + AW'(col) + AW'(pass) * AW'(PASS_STRIDE) + AW'(1));
    // abort masks the offer so the consumer never sees a handshake that does not write
    assign out_valid = fill && !abort;
    assign wr = out_valid && out_ready;
    assign out_row = row;
    assign out_col = col;
    assign out_pass = pass;
    assign out_data = fill ? data_w : '0;
    assign a_flat = arr;
    assign busy = state != IDLE;
    assign done = state == DONE && !abort;
    always_comb begin
        state_d = state;
        row_d = row;
        col_d = col;
        pass_d = pass;
        gap_d = gap;
        if (abort && state != IDLE) begin
            state_d = IDLE;
            row_d = '0;
            col_d = '0;
            pass_d = '0;
            gap_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = start ? FILL : IDLE;
                    row_d = '0;
                    col_d = '0;
                    pass_d = '0;
                    gap_d = '0;
                end
                FILL: if (out_ready) begin
                    col_d = last_col ? '0 : col + 1'b1;
                    row_d = !last_col ? row : last_row ? '0 : row + 1'b1;
                    if (last_col && last_row) begin
                        state_d = last_pass ? DONE : GAP;
                        pass_d = last_pass ? pass : pass + 1'b1;
                        gap_d = '0;
                    end
                end
                GAP: begin
                    state_d = last_gap ? FILL : GAP;
                    gap_d = last_gap ? '0 : gap + 1'b1;
                end
                DONE: begin
                    state_d = IDLE;
                    pass_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            row <= '0;
            col <= '0;
            pass <= '0;
            gap <= '0;
            arr <= '0;
        end else begin
            state <= state_d;
            row <= row_d;
            col <= col_d;
            pass <= pass_d;
            gap <= gap_d;
            if (wr)
                arr[row][col] <= data_w;
        end
    end
endmodule

// File: tb/tb_array_sweep_ctrl.sv
// tb_array_sweep_ctrl: scoreboard bench; a cycle-level schedule model predicts every write, a monitor checks them
module tb_array_sweep_ctrl;
    localparam int ROWS = 4, COLS = 2, WIDTH = 16, PASSES = 2, STRIDE = 10, GAP = 1;
    localparam int RW = 2, CW = 1, PW = 1, FW = ROWS * COLS * WIDTH;
    typedef struct {int row; int col; int pas; int data;} wr_t;
    logic clk = 0, rst = 1, start = 0, abort = 0, out_ready = 0;
    logic out_valid, busy, done, n_valid, n_busy, n_done;
    logic [RW-1:0] out_row, n_row;
    logic [CW-1:0] out_col, n_col;
    logic [PW-1:0] out_pass, n_pass;
    logic [WIDTH-1:0] out_data;
    logic [3:0] n_data;
    logic [FW-1:0] a_flat;
    logic [ROWS*COLS*4-1:0] n_flat;
    logic [FW-1:0] exp_flat = '0;
    wr_t exp_q[$];
    wr_t mon_e;
    bit rdy[1024];
    int checks = 0, errors = 0, cyc = 0, n_xfer = 0, n_donep = 0, done_cyc = -1;
    always #5 clk = ~clk;
    array_sweep_ctrl #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .PASSES(PASSES),
                       .PASS_STRIDE(STRIDE), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .out_col(out_col), .out_pass(out_pass),
        .out_data(out_data), .a_flat(a_flat), .busy(busy), .done(done));
    array_sweep_ctrl #(.ROWS(ROWS), .COLS(COLS), .WIDTH(4), .PASSES(PASSES),
                       .PASS_STRIDE(13), .GAP_CYCLES(GAP)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(1'b0), .out_valid(n_valid),
        .out_ready(1'b1), .out_row(n_row), .out_col(n_col), .out_pass(n_pass),
        .out_data(n_data), .a_flat(n_flat), .busy(n_busy), .done(n_done));
    function automatic int dat(int i, int k, int p, int s, int w);
        return (i + 1 + p * s + k) % (1 << w);
    endfunction
    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, got, expv, cyc);
        end
    endtask
    // walks the fill order against the ready pattern; writes at or after cycle ab never land
    task automatic schedule(input int ab, output int dc);
        int c = 1;
        for (int p = 0; p < PASSES; p++) begin
            for (int i = 0; i < ROWS; i++)
                for (int k = 0; k < COLS; k++) begin
                    while (!rdy[c] && c < 1000) c++;
                    if (ab == 0 || c < ab) begin
                        exp_q.push_back('{i, k, p, dat(i, k, p, STRIDE, WIDTH)});
                        exp_flat[(i*COLS+k)*WIDTH +: WIDTH] = WIDTH'(dat(i, k, p, STRIDE, WIDTH));
                    end
                    c++;
                end
            if (p < PASSES - 1) c += GAP;
        end
        dc = c;
    endtask
    task automatic run(input int ab, input int glitch, input int rst_c);
        int dc, nx0, nd0, nexp, last;
        bit ab_eff;
        nx0 = n_xfer;
        nd0 = n_donep;
        schedule(rst_c > 0 ? rst_c : ab, dc);
        nexp = exp_q.size();
        ab_eff = (ab > 0 && ab <= dc) || rst_c > 0;
        last = ab_eff ? (rst_c > 0 ? rst_c : ab) + 2 : dc + 2;
        cyc = 0;
        start = 1;
        abort = 0;
        out_ready = rdy[0];
        while (cyc < last) begin
            @(posedge clk);
            #1;
            cyc++;
            start = cyc == glitch && cyc <= dc && !(ab_eff && cyc > ab);
            abort = cyc == ab;
            out_ready = rdy[cyc];
            if (ab_eff && rst_c == 0 && cyc == ab + 1)
                chk("abort_idle", {busy, out_valid}, 0);
            if (cyc == rst_c) begin
                chk("gap_state", {busy, out_valid}, 2'b10);
                #2 rst = 1;
                #1;
                chk("rst_flat", a_flat, 0);
                chk("rst_outs", {busy, out_valid, done}, 0);
                exp_flat = '0;
            end
        end
        start = 0;
        abort = 0;
        rst = 0;
        @(negedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        chk("xfer_count", n_xfer - nx0, nexp);
        chk("done_count", n_donep - nd0, ab_eff ? 0 : 1);
        if (!ab_eff) chk("done_cycle", done_cyc, dc);
        chk("a_flat", a_flat, exp_flat);
        chk("idle_after", {busy, out_valid, done}, 0);
        exp_q.delete();
    endtask
    initial begin
        bit prev_stall = 0;
        logic [RW+CW+PW+WIDTH-1:0] prev_out = '0;
        forever begin
            @(negedge clk);
            if (rst) prev_stall = 0;
            else begin
                if (prev_stall && !abort)
                    chk("stall_hold", {out_valid, out_row, out_col, out_pass, out_data}, {1'b1, prev_out});
                if (out_valid && out_ready) begin
                    n_xfer++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL xfer_unexpected got row %0d col %0d data %0h, none expected", out_row, out_col, out_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("xfer", {out_row, out_col, out_pass, out_data},
                            {RW'(mon_e.row), CW'(mon_e.col), PW'(mon_e.pas), WIDTH'(mon_e.data)});
                    end
                end
                if (done) begin
                    n_donep++;
                    done_cyc = cyc;
                end
                prev_stall = out_valid && !out_ready;
                prev_out = {out_row, out_col, out_pass, out_data};
            end
        end
    end
    initial begin
        logic [ROWS*COLS*4-1:0] e4;
        #2;
        chk("reset_outs", {out_valid, busy, done, out_row, out_col, out_pass, out_data}, 0);
        chk("reset_flat", a_flat, 0);
        @(posedge clk);
        #1;
        rst = 0;
        foreach (rdy[c]) rdy[c] = 1;
        run(0, 0, 0);
        chk("done_at_18", done_cyc, 18);
        chk("a00_final", a_flat[0 +: 16], 11);
        chk("a31_final", a_flat[112 +: 16], 15);
        chk("a20_final", a_flat[64 +: 16], 13);
        e4 = '0;
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < COLS; k++)
                e4[(i*COLS+k)*4 +: 4] = 4'(dat(i, k, PASSES - 1, 13, 4));
        chk("narrow_flat", n_flat, e4);
        chk("narrow_wrap31", n_flat[28 +: 4], 2);
        foreach (rdy[c]) rdy[c] = (c % 2) == 1;
        run(0, 4, 0);
        foreach (rdy[c]) rdy[c] = 1;
        run(5, 0, 0);
        chk("abort_a00", a_flat[0 +: 16], 1);
        chk("abort_a11", a_flat[48 +: 16], 3);
        run(0, 0, 0);
        for (int it = 0; it < 12; it++) begin
            int pr, ab, gl;
            pr = $urandom_range(25, 100);
            foreach (rdy[c]) rdy[c] = $urandom_range(1, 100) <= pr;
            ab = $urandom_range(0, 2) == 0 ? $urandom_range(1, 40) : 0;
            gl = $urandom_range(1, 30);
            run(ab, gl, 0);
        end
        foreach (rdy[c]) rdy[c] = 1;
        run(0, 0, 9);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
